// File: rtl/echo_pkg.sv
// Shared types and constants for the UART echo block.
package echo_pkg;

   localparam int DATA_BITS  = 8;
   localparam int FIFO_DEPTH = 2;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

endpackage

// File: rtl/echo_if.sv
// Byte handshakes between the serial engine (master) and the byte buffer (slave).
interface echo_if;
   import echo_pkg::*;

   logic [DATA_BITS-1:0] rx_byte;
   logic                 rx_valid;
   logic [DATA_BITS-1:0] tx_byte;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output rx_byte, rx_valid, tx_ready, input tx_byte, tx_valid);
   modport slave  (input rx_byte, rx_valid, tx_ready, output tx_byte, tx_valid);

endinterface

// File: rtl/echo_serial.sv
// 8N1 UART receiver and transmitter. Received bytes leave as a one-cycle valid
// pulse; bytes to send are taken on a valid/ready handshake.
module echo_serial
   import echo_pkg::*;
#(
   parameter int CLKS_PER_BIT = 6
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_rxd,
   output logic   o_txd,
   echo_if.master bus
);

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT);
   localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
   localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

   logic r_rx_meta, r_rx_sync, r_rx_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= i_rxd;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   rx_state_t            r_rx_state;
   logic [15:0]          r_rx_cnt;
   logic [2:0]           r_rx_idx;
   logic [DATA_BITS-1:0] r_rx_shift;
   logic [DATA_BITS-1:0] r_rx_byte;
   logic                 r_rx_valid;

   assign bus.rx_byte  = r_rx_byte;
   assign bus.rx_valid = r_rx_valid;

   // Counter restarts at 1 on each sample, so the next sample lands one bit period later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_shift <= '0;
         r_rx_byte  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         unique case (r_rx_state)
            RX_IDLE: begin
               if (r_rx_prev && !r_rx_sync) begin
                  r_rx_state <= RX_START;
                  r_rx_cnt   <= 16'd1;
               end
            end
            RX_START: begin
               if (r_rx_cnt == HALF_BIT) begin
                  r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                  r_rx_cnt   <= 16'd1;
                  r_rx_idx   <= '0;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (r_rx_cnt == BIT_LAST) begin
                  r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                  r_rx_cnt   <= 16'd1;
                  r_rx_idx   <= r_rx_idx + 3'd1;
                  if (r_rx_idx == LAST_IDX) r_rx_state <= RX_STOP;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (r_rx_cnt == BIT_LAST) begin
                  r_rx_cnt <= '0;
                  if (r_rx_sync) begin
                     r_rx_byte  <= r_rx_shift;
                     r_rx_valid <= 1'b1;
                     r_rx_state <= RX_IDLE;
                  end else begin
                     r_rx_state <= RX_WAIT_IDLE;
                  end
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            RX_WAIT_IDLE: begin
               if (r_rx_sync) r_rx_state <= RX_IDLE;
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   tx_state_t            r_tx_state;
   logic [15:0]          r_tx_cnt;
   logic [2:0]           r_tx_idx;
   logic [DATA_BITS-1:0] r_tx_shift;
   logic                 r_txd;
   logic                 w_tx_bit_end;

   assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);
   // Ready in the last stop-bit cycle lets a queued byte start with no idle gap.
   assign bus.tx_ready = (r_tx_state == TX_IDLE) || (r_tx_state == TX_STOP && w_tx_bit_end);
   assign o_txd        = r_txd;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_shift <= '0;
         r_txd      <= 1'b1;
      end else begin
         unique case (r_tx_state)
            TX_IDLE: begin
               if (bus.tx_valid) begin
                  r_tx_shift <= bus.tx_byte;
                  r_txd      <= 1'b0;
                  r_tx_cnt   <= 16'd1;
                  r_tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (w_tx_bit_end) begin
                  r_txd      <= r_tx_shift[0];
                  r_tx_cnt   <= 16'd1;
                  r_tx_idx   <= '0;
                  r_tx_state <= TX_DATA;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            TX_DATA: begin
               if (w_tx_bit_end) begin
                  r_tx_cnt <= 16'd1;
                  if (r_tx_idx == LAST_IDX) begin
                     r_txd      <= 1'b1;
                     r_tx_state <= TX_STOP;
                  end else begin
                     r_tx_idx   <= r_tx_idx + 3'd1;
                     r_tx_shift <= r_tx_shift >> 1;
                     r_txd      <= r_tx_shift[1];
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            TX_STOP: begin
               if (w_tx_bit_end) begin
                  if (bus.tx_valid) begin
                     r_tx_shift <= bus.tx_byte;
                     r_txd      <= 1'b0;
                     r_tx_cnt   <= 16'd1;
                     r_tx_state <= TX_START;
                  end else begin
                     r_tx_cnt   <= '0;
                     r_tx_state <= TX_IDLE;
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/echo.sv
// UART echo: every correctly framed byte received on rxd is resent on txd,
// buffered through a small FIFO between the receiver and the transmitter.
module echo
   import echo_pkg::*;
#(
   parameter int CLKS_PER_BIT = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic rxd,
   output logic txd
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   echo_if u_bus ();

   echo_serial #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_serial (
      .clk   (clk),
      .rst   (rst),
      .i_rxd (rxd),
      .o_txd (txd),
      .bus   (u_bus.master)
   );

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]        r_count;
   logic                 w_push, w_pop;

   assign u_bus.tx_valid = (r_count != '0);
   assign u_bus.tx_byte  = r_mem[r_rd_ptr];
   assign w_pop          = u_bus.tx_valid && u_bus.tx_ready;
   // A full buffer still accepts a byte when the head leaves in the same cycle.
   assign w_push         = u_bus.rx_valid && ((r_count != CW'(FIFO_DEPTH)) || w_pop);

   // NOTE: storage is not reset; entries are only ever read while r_count says they are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= u_bus.rx_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_echo.sv
// Bench for echo: drives UART frames on rxd, decodes txd cycle by cycle and
// compares echoed bytes against the queue of correctly framed bytes sent.
module tb_echo;

   localparam int CPB       = 6;
   localparam int FRAME_CYC = 10 * CPB;

   logic clk;
   logic rst;
   logic rxd;
   logic txd;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   echo #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .rxd (rxd),
      .txd (txd)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // txd decoder: captures a whole frame cycle by cycle, so every bit width is checked too.
   initial begin : tx_monitor
      logic       samples [FRAME_CYC];
      logic [9:0] frame;
      logic [7:0] b;
      logic       aborted;
      logic       shape_ok;
      forever begin
         @(negedge clk);
         if (!rst && txd === 1'b0) begin
            aborted    = 1'b0;
            samples[0] = txd;
            for (int k = 1; k < FRAME_CYC; k++) begin
               @(negedge clk);
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               samples[k] = txd;
            end
            if (!aborted) begin
               for (int i = 0; i < 8; i++) b[i] = samples[(i + 1) * CPB + CPB / 2];
               frame    = {1'b1, b, 1'b0};
               shape_ok = 1'b1;
               for (int k = 0; k < FRAME_CYC; k++)
                  if (samples[k] !== frame[k / CPB]) shape_ok = 1'b0;
               check("tx_frame_shape", 32'(shape_ok), 32'd1);
               got_q.push_back(b);
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int idle_bits);
      logic [9:0] f;
      f = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = f[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (idle_bits * CPB) @(negedge clk);
      if (stop_ok) exp_q.push_back(b);
   endtask

   task automatic drain(input string tag);
      int waited;
      waited = 0;
      while (got_q.size() < exp_q.size() && waited < 40 * CPB) begin
         @(negedge clk);
         waited++;
      end
      repeat (12 * CPB) @(negedge clk);
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0)
         check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic count_low(input int cycles, output int lows);
      lows = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
   endtask

   initial begin : stimulus
      int         lows;
      logic [7:0] rb;
      logic       bad;
      rst = 1'b1;
      rxd = 1'b1;

      // Reset holds the line idle.
      @(negedge clk);
      check("reset_txd_c0", 32'(txd), 32'd1);
      @(negedge clk);
      check("reset_txd_c1", 32'(txd), 32'd1);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single byte.
      send_frame(8'hA5, 1'b1, 0);
      drain("single_a5");

      // Four frames with three idle bits between.
      send_frame(8'hAA, 1'b1, 3);
      send_frame(8'hAA, 1'b1, 3);
      send_frame(8'h55, 1'b1, 3);
      send_frame(8'h55, 1'b1, 3);
      drain("gap3_burst");

      // Framing error is discarded; the following good byte is echoed.
      send_frame(8'h3C, 1'b0, 2);
      send_frame(8'h81, 1'b1, 0);
      drain("framing_err");

      // Short low glitch must not start a frame.
      rxd = 1'b0;
      repeat (2) @(negedge clk);
      rxd = 1'b1;
      count_low(20 * CPB, lows);
      check("glitch_txd_low_cycles", 32'(lows), 32'd0);
      check("glitch_no_bytes", 32'(got_q.size()), 32'd0);

      // Reset during the data bits of an echo.
      send_frame(8'h5A, 1'b1, 0);
      repeat (3 * CPB) @(negedge clk);
      check("pre_reset_echo_busy", 32'(got_q.size()), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_reset_txd_c0", 32'(txd), 32'd1);
      @(negedge clk);
      check("mid_reset_txd_c1", 32'(txd), 32'd1);
      rst = 1'b0;
      count_low(15 * CPB, lows);
      check("post_reset_txd_low_cycles", 32'(lows), 32'd0);
      check("post_reset_no_bytes", 32'(got_q.size()), 32'd0);
      exp_q.delete();
      got_q.delete();
      send_frame(8'hC3, 1'b1, 2);
      drain("after_reset");

      // Three frames with no idle between.
      send_frame(8'h12, 1'b1, 0);
      send_frame(8'hF0, 1'b1, 0);
      send_frame(8'h0F, 1'b1, 0);
      drain("zero_gap");

      // Random bytes, gaps and occasional framing errors.
      for (int i = 0; i < 14; i++) begin
         rb  = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 5) == 0);
         send_frame(rb, !bad, bad ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3)));
      end
      drain("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
